// File: rtl/ysyx_041514_alu_mul_ctrl_pkg.sv
// Shared widths, op encodings and helpers for the iterative RV64M multiply sequencer.
// Pure declarations: no latency, no flow control.
package ysyx_041514_alu_mul_ctrl_pkg;

  localparam int XLEN       = 64;
  localparam int MUL_OP_BUS = 3;
  localparam int MUL_GROUPS = 9;
  localparam int PP_NUM     = 33;
  localparam int PP_W       = XLEN + 2;
  localparam int ACC_W      = 2 * XLEN;
  localparam int TERM_SLOTS = 4 * MUL_GROUPS;

  typedef enum logic [MUL_OP_BUS-1:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Reserved codes 5..7 fold onto plain MUL.
  function automatic mul_op_e decode_op(input logic [MUL_OP_BUS-1:0] code);
    mul_op_e op;
    case (code)
      3'd1:    op = MUL_OP_MULH;
      3'd2:    op = MUL_OP_MULHSU;
      3'd3:    op = MUL_OP_MULHU;
      3'd4:    op = MUL_OP_MULW;
      default: op = MUL_OP_MUL;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input mul_op_e op, input logic [ACC_W-1:0] acc);
    logic [XLEN-1:0] r;
    case (op)
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: r = acc[ACC_W-1:XLEN];
      MUL_OP_MULW:                              r = sext32(acc[31:0]);
      default:                                  r = acc[XLEN-1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_041514_alu_mul_ctrl_booth.sv
// Radix-4 Booth partial-product generator: 33 unshifted 66-bit signed products digit_k * a.
// Purely combinational, no flow control.
module ysyx_041514_alu_mul_ctrl_booth
  import ysyx_041514_alu_mul_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]              a,
  input  logic [XLEN-1:0]              b,
  input  logic                         a_signed,
  input  logic                         b_signed,
  output logic [PP_NUM-1:0][PP_W-1:0]  pp
);

  logic [PP_W-1:0] a_ext;
  logic [PP_W:0]   b_ext;

  // Two extension bits on b give an even digit count; the trailing zero is b[-1].
  assign a_ext = {{2{a_signed & a[XLEN-1]}}, a};
  assign b_ext = {{2{b_signed & b[XLEN-1]}}, b, 1'b0};

  for (genvar k = 0; k < PP_NUM; k++) begin : g_pp
    logic [2:0]      dig;
    logic [PP_W-1:0] mag;
    logic            neg;

    assign dig = b_ext[2*k+2 -: 3];

    always_comb begin
      mag = '0;
      neg = 1'b0;
      case (dig)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_ext << 1;
        3'b100: begin
          mag = a_ext << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_ext;
          neg = 1'b1;
        end
        default: ;
      endcase
    end

    // |2a| stays below 2^65, so negation never overflows 66 bits.
    assign pp[k] = neg ? -mag : mag;
  end

endmodule

// File: rtl/ysyx_041514_alu_mul_ctrl.sv
// Iterative RV64M multiply: four Booth partial products summed per cycle, result valid 10 cycles after accept.
// Holds the result until resp_ready; a new request may be accepted in the same cycle the result is taken.
module ysyx_041514_alu_mul_ctrl
  import ysyx_041514_alu_mul_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [MUL_OP_BUS-1:0] mul_op_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  flush_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       result_o
);

  localparam logic [3:0] LAST_GROUP = 4'(MUL_GROUPS - 1);

  mul_state_e                 state;
  logic [3:0]                 cnt;
  logic [XLEN-1:0]            rs1_q;
  logic [XLEN-1:0]            rs2_q;
  logic                       rs1_signed_q;
  logic                       rs2_signed_q;
  mul_op_e                    op_q;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           grp_sum;
  logic [ACC_W-1:0]           acc_next;
  logic [XLEN-1:0]            result_q;
  logic [PP_NUM-1:0][PP_W-1:0] pp;
  logic [ACC_W-1:0]           term [TERM_SLOTS];

  mul_op_e         op_dec;
  logic [XLEN-1:0] rs1_dec;
  logic [XLEN-1:0] rs2_dec;
  logic            rs1_signed_dec;
  logic            rs2_signed_dec;
  logic            accept;

  assign req_ready_o  = !flush_i && ((state == ST_IDLE) || ((state == ST_DONE) && resp_ready_i));
  assign resp_valid_o = (state == ST_DONE);
  assign result_o     = result_q;
  assign accept       = req_valid_i && req_ready_o;

  always_comb begin
    op_dec         = decode_op(mul_op_i);
    rs1_dec        = rs1_data_i;
    rs2_dec        = rs2_data_i;
    rs1_signed_dec = 1'b1;
    rs2_signed_dec = 1'b1;
    case (op_dec)
      MUL_OP_MULHSU: rs2_signed_dec = 1'b0;
      MUL_OP_MULHU: begin
        rs1_signed_dec = 1'b0;
        rs2_signed_dec = 1'b0;
      end
      MUL_OP_MULW: begin
        rs1_dec = sext32(rs1_data_i[31:0]);
        rs2_dec = sext32(rs2_data_i[31:0]);
      end
      default: ;
    endcase
  end

  ysyx_041514_alu_mul_ctrl_booth u_booth (
    .a        (rs1_q),
    .b        (rs2_q),
    .a_signed (rs1_signed_q),
    .b_signed (rs2_signed_q),
    .pp       (pp)
  );

  // Place each product at weight 4^k, sign-extended to the accumulator width;
  // slots past pp32 stay zero so group 8 adds pp32 alone.
  for (genvar k = 0; k < TERM_SLOTS; k++) begin : g_term
    if (k < PP_NUM) begin : g_used
      assign term[k] = {{(ACC_W-PP_W){pp[k][PP_W-1]}}, pp[k]} << (2*k);
    end else begin : g_pad
      assign term[k] = '0;
    end
  end

  always_comb begin
    grp_sum = '0;
    for (int j = 0; j < 4; j++) begin
      grp_sum = grp_sum + term[{cnt, 2'b00} + 6'(j)];
    end
  end

  assign acc_next = acc + grp_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      acc          <= '0;
      result_q     <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_signed_q <= 1'b0;
      rs2_signed_q <= 1'b0;
      op_q         <= MUL_OP_MUL;
    end else if (flush_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (accept) begin
      state        <= ST_CALC;
      cnt          <= '0;
      acc          <= '0;
      rs1_q        <= rs1_dec;
      rs2_q        <= rs2_dec;
      rs1_signed_q <= rs1_signed_dec;
      rs2_signed_q <= rs2_signed_dec;
      op_q         <= op_dec;
    end else begin
      case (state)
        ST_CALC: begin
          acc <= acc_next;
          if (cnt == LAST_GROUP) begin
            state    <= ST_DONE;
            cnt      <= '0;
            result_q <= sel_result(op_q, acc_next);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: if (resp_ready_i) state <= ST_IDLE;
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_041514_alu_mul_ctrl.md
# ysyx_041514_alu_mul_ctrl

Multi-cycle sequencer for the RV64M multiply path. It accepts one multiply request and registers the operands. It drives the radix-4 Booth partial-product generator and accumulates its 33 partial products into a 128-bit accumulator, four per cycle over 9 cycles. It then returns the selected 64-bit result over a valid/ready response channel. It sits between the EXU issue logic and the writeback mux, replacing the single-cycle Wallace-tree summation to relieve timing.

## Interface
- No parameters; widths come from `ysyx_041514_XLEN` (64) in the shared config.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both valid and ready are high.
- `mul_op_i` in 3: operation code; encodings MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4; codes 5–7 are treated as MUL.
- `rs1_data_i` in 64: multiplicand.
- `rs2_data_i` in 64: multiplier.
- `flush_i` in 1: kills any in-flight or pending operation.
- `resp_valid_o` out 1: result valid.
- `resp_ready_i` in 1: consumer ready.
- `result_o` out 64: result; held stable while `resp_valid_o` is high and `resp_ready_i` is low.

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1.
  - CALC: holds group counter `cnt` (4 bits, 0..8).
  - DONE: `resp_valid_o`=1.
- Accept (IDLE, or DONE with `resp_ready_i`=1), on a handshake:
  - Register the operands, signed flags and op.
  - Clear the accumulator and set `cnt`=0.
  - Next state is CALC.
- Signed flags by op:
  - MUL and MULH: s/s.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: u/u.
  - MULW: both operands replaced by sext(x[31:0]), then s/s.
- Booth generator inputs come from the registered operands only; the generator is combinational and instanced inside this block.
- Accumulation in CALC:
  - Each cycle, `acc <= acc + Σ sx(pp_k)` for k = 4·cnt .. 4·cnt+3, restricted to k ≤ 32.
  - Group 8 adds pp32 only.
- sx(pp_k): sign-extend from bit 2k+65 up to bit 127 before the add. pp32 is used as-is, because its upper bits fall beyond 128. All arithmetic is mod 2^128.
- CALC exit: when `cnt`==8, the next state is DONE; otherwise `cnt` increments.
- Result select, registered on entry to DONE:
  - MUL: acc[63:0].
  - MULH, MULHSU, MULHU: acc[127:64].
  - MULW: sext(acc[31:0]).
- Leaving DONE:
  - Handshake with no new request: go to IDLE.
  - Handshake with a new request in the same cycle: go to CALC with the new operands.
- Flush: `flush_i`=1 in any state sends the next state to IDLE with no response. It has priority over an accept in the same cycle. `req_ready_o` is forced to 0 while `flush_i`=1.
- Reset: state IDLE, `cnt`=0, acc=0, `result_o`=0, `resp_valid_o`=0, `req_ready_o`=1 after the reset edge.

## Timing
- Request accepted in cycle A. CALC occupies A+1..A+9. `resp_valid_o`=1 from cycle A+10.
- Fixed latency of 10 cycles. Throughput is one multiply per 10 cycles when back-to-back acceptance in DONE is used.
- `req_ready_o` and `resp_valid_o` are decoded from registered state only. `req_ready_o` in DONE is the single exception: it is gated combinationally by `resp_ready_i` and `flush_i`.
- No combinational path from `req_valid_i` to any output.
- A mid-CALC flush discards the accumulator. The next request in the following cycle starts from acc=0.
- Reset mid-operation behaves identically to flush.

## Structure
- Shared package/config `sysconfig.v` gets `ysyx_041514_MUL_OP_*` encodings, the `ysyx_041514_MUL_OP_BUS` width (3), and `ysyx_041514_MUL_GROUPS` (9).
- One sub-module, the existing Booth radix-4 partial-product generator, instanced once.
- The 4-PP sign-extend-and-add is a local function or generate loop, not a separate module.

## Test plan
- MUL rs1=3, rs2=5 accepted at cycle A → `resp_valid_o` rises at A+10, `result_o`=15.
- MULHU rs1=rs2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULH with the same operands → 0x0.
- MULHSU rs1=0xFFFFFFFFFFFFFFFF (−1), rs2=2 → 0xFFFFFFFFFFFFFFFF. MULW rs1=0x7FFFFFFF, rs2=2 → 0xFFFFFFFFFFFFFFFE.
- Hold `resp_ready_i`=0 for 5 cycles in DONE → `result_o` stable and `resp_valid_o` held. Then assert `resp_ready_i` together with a new MUL 7×6 → accepted the same cycle, second result 42 exactly 10 cycles later.
- `flush_i` pulsed at A+4 → no `resp_valid_o` ever for that op, `req_ready_o`=1 at A+5. A new MUL 2×2 issued then → 4.
- Flush and `req_valid_i` in the same IDLE cycle → request not accepted (`req_ready_o`=0). Random signed/unsigned corner sweep (0, ±1, INT64_MIN, INT64_MAX) matches the reference model.
